data_sram_arbiter: RTL and testbench

- Shares one SRAM-like data port (req / addr_ok / data_ok split handshake) between two masters:
  - m0: pipeline EXE/MEM data side.
  - m1: secondary master (instruction fetch or refill side).
- Picks a winner each cycle using round-robin priority.
- Holds the grant stable until the slave accepts the address.
- Keeps an in-order ID FIFO of accepted transactions, so each data_ok/rdata returns to the master that issued it.
- Sits between the pipeline stages and the memory bridge.

---
 rtl/data_sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_data_sram_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_arbiter.sv
// Two-master arbiter for a split-handshake SRAM-like data port.
// Round-robin grant, held while the slave stalls the address phase, with an
// in-order ID FIFO that steers each response back to its issuing master.
module data_sram_arbiter #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_unexp
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUT);

  logic               rr_ptr;
  logic               lock;
  logic               lock_id;
  logic [MAX_OUT-1:0] id_fifo;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic gnt_c;
  logic sel_req_c;
  logic hs_c;
  logic pop_c;
  logic head_c;

  // Grant: a stalled winner keeps the port; otherwise lone requester or rr_ptr
  always_comb begin
    gnt_c = rr_ptr;
    if (lock) begin
      gnt_c = lock_id;
    end else if (m0_req && !m1_req) begin
      gnt_c = 1'b0;
    end else if (m1_req && !m0_req) begin
      gnt_c = 1'b1;
    end
  end

  // Slave request mux; issue is blocked while the ID FIFO is full
  always_comb begin
    sel_req_c = gnt_c ? m1_req : m0_req;
    s_req     = sel_req_c && (count != FULL);
    s_wr      = gnt_c ? m1_wr    : m0_wr;
    s_size    = gnt_c ? m1_size  : m0_size;
    s_addr    = gnt_c ? m1_addr  : m0_addr;
    s_wdata   = gnt_c ? m1_wdata : m0_wdata;
    s_wstrb   = s_req ? (gnt_c ? m1_wstrb : m0_wstrb) : 4'b0000;
    hs_c       = s_req && s_addr_ok;
    m0_addr_ok = hs_c && !gnt_c;
    m1_addr_ok = hs_c && gnt_c;
  end

  // Response steering from the FIFO head; a response with nothing pending is dropped
  always_comb begin
    pop_c      = s_data_ok && (count != '0);
    head_c     = id_fifo[rd_ptr];
    m0_data_ok = pop_c && !head_c;
    m1_data_ok = pop_c && head_c;
    m0_rdata   = m0_data_ok ? s_rdata : 32'h0;
    m1_rdata   = m1_data_ok ? s_rdata : 32'h0;
  end

  // Arbitration state: round-robin pointer and stall lock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr  <= 1'b0;
      lock    <= 1'b0;
      lock_id <= 1'b0;
    end else begin
      if (hs_c) begin
        rr_ptr <= ~gnt_c;
      end
      lock <= s_req && !s_addr_ok;
      if (s_req && !s_addr_ok) begin
        lock_id <= gnt_c;
      end
    end
  end

  // In-order ID FIFO of accepted transactions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_fifo <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (hs_c) begin
        id_fifo[wr_ptr] <= gnt_c;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({hs_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a response arriving with no transaction outstanding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_unexp <= 1'b0;
    end else if (s_data_ok && (count == '0)) begin
      err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Self-checking bench for data_sram_arbiter: directed scenarios followed by
// random traffic, all compared each cycle against a queue-based reference model.
module tb_data_sram_arbiter;

  localparam int unsigned MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;
  logic        err_unexp;

  data_sram_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: who issued each outstanding transaction, oldest first
  bit owners[$];
  bit next_first;   // master favoured when both contend
  bit held;         // a stalled request owns the port
  bit held_by;
  bit saw_stray;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owners.delete();
    next_first = 1'b0;
    held       = 1'b0;
    held_by    = 1'b0;
    saw_stray  = 1'b0;
  endtask

  task automatic idle();
    m0_req = 0; m0_wr = 0; m0_size = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  // One clock: inputs already applied at the falling edge; check, clock, update model
  task automatic step();
    bit who, wants, issue, accept, respond, to_m1;
    int pending;
    #1;
    pending = owners.size();
    if (held)                     who = held_by;
    else if (m0_req != m1_req)    who = m1_req;
    else                          who = next_first;
    wants   = who ? m1_req : m0_req;
    issue   = wants && (pending < MAX_OUT);
    accept  = issue && s_addr_ok;
    respond = s_data_ok && (pending > 0);
    to_m1   = respond ? owners[0] : 1'b0;

    chk("s_req", s_req, issue);
    if (issue) begin
      chk("s_wr",    s_wr,    who ? m1_wr    : m0_wr);
      chk("s_size",  s_size,  who ? m1_size  : m0_size);
      chk("s_addr",  s_addr,  who ? m1_addr  : m0_addr);
      chk("s_wdata", s_wdata, who ? m1_wdata : m0_wdata);
    end
    chk("s_wstrb",    s_wstrb,    issue ? (who ? m1_wstrb : m0_wstrb) : 4'h0);
    chk("m0_addr_ok", m0_addr_ok, accept && !who);
    chk("m1_addr_ok", m1_addr_ok, accept && who);
    chk("m0_data_ok", m0_data_ok, respond && !to_m1);
    chk("m1_data_ok", m1_data_ok, respond && to_m1);
    chk("m0_rdata",   m0_rdata,   (respond && !to_m1) ? s_rdata : 32'h0);
    chk("m1_rdata",   m1_rdata,   (respond && to_m1)  ? s_rdata : 32'h0);
    chk("err_unexp",  err_unexp,  saw_stray);

    @(posedge clk);
    if (respond) void'(owners.pop_front());
    if (accept) begin
      owners.push_back(who);
      next_first = !who;
    end
    if (s_data_ok && pending == 0) saw_stray = 1'b1;
    held    = issue && !s_addr_ok;
    held_by = who;
    @(negedge clk);
  endtask

  // Reset while a stray response is presented: nothing may be routed or flagged
  task automatic do_reset();
    resetn = 1'b0;
    idle();
    s_data_ok = 1'b1;
    #1;
    chk("rst_s_req",      s_req,      1'b0);
    chk("rst_m0_data_ok", m0_data_ok, 1'b0);
    chk("rst_m1_data_ok", m1_data_ok, 1'b0);
    chk("rst_err",        err_unexp,  1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    s_data_ok = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single master read
    m0_req = 1; m0_addr = 32'h1000; s_addr_ok = 1;
    #1 chk("single_aok", m0_addr_ok, 1'b1);
    step();
    idle(); step(); step();
    s_data_ok = 1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("single_dok",   m0_data_ok, 1'b1);
    chk("single_rdata", m0_rdata,   32'hDEADBEEF);
    chk("single_m1dok", m1_data_ok, 1'b0);
    step();

    // Contention from reset: grants alternate starting with m0
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h100; m1_addr = 32'h200; s_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_gnt_m1", m1_addr_ok, 32'(i % 2));
      step();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      s_data_ok = 1; s_rdata = 32'(i + 16);
      #1 chk("cont_rsp_m1", m1_data_ok, 32'(i % 2));
      step();
    end

    // Lock: m0 wins and is held across a 3-cycle stall
    idle();
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'hA000; m1_addr = 32'hB000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_addr",  s_addr,     32'hA000);
      chk("lock_m1aok", m1_addr_ok, 1'b0);
      step();
    end
    s_addr_ok = 1;
    #1 chk("lock_m0aok", m0_addr_ok, 1'b1);
    step();
    #1 chk("lock_m1next", m1_addr_ok, 1'b1);
    step();
    idle();
    s_data_ok = 1; step(); step();

    // FIFO full, pop does not unblock same cycle, push+pop together
    idle();
    do_reset();
    m0_req = 1; s_addr_ok = 1; m0_addr = 32'h3000;
    repeat (4) step();
    #1 chk("full_block", s_req, 1'b0);
    step();
    s_data_ok = 1;
    #1 chk("full_pop_same", s_req, 1'b0);
    step();
    s_data_ok = 0;
    #1 chk("full_unblock", m0_addr_ok, 1'b1);
    step();
    m0_req = 0; s_data_ok = 1; step();
    m0_req = 1; step();
    s_data_ok = 0; step();
    #1 chk("full_again", s_req, 1'b0);
    step();
    idle();
    s_data_ok = 1;
    repeat (4) step();

    // Reset with two outstanding, then a stray response
    idle();
    m0_req = 1; s_addr_ok = 1;
    step(); step();
    do_reset();
    s_data_ok = 1; s_rdata = 32'h55;
    #1;
    chk("stray_m0dok", m0_data_ok, 1'b0);
    chk("stray_m1dok", m1_data_ok, 1'b0);
    step();
    s_data_ok = 0;
    #1 chk("stray_err", err_unexp, 1'b1);
    step();

    // Write path from m1
    do_reset();
    m1_req = 1; m1_wr = 1; m1_wstrb = 4'b0011; m1_size = 2'd1;
    m1_addr = 32'h2002; m1_wdata = 32'h0000_1234; s_addr_ok = 1;
    #1;
    chk("wr_s_wr",    s_wr,    1'b1);
    chk("wr_s_wstrb", s_wstrb, 4'b0011);
    chk("wr_s_size",  s_size,  2'd1);
    chk("wr_s_addr",  s_addr,  32'h2002);
    step();
    idle();
    s_data_ok = 1;
    #1 chk("wr_rsp_m1", m1_data_ok, 1'b1);
    step();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      m0_req = ($urandom_range(0, 9) < 6);
      m1_req = ($urandom_range(0, 9) < 6);
      if (held && !held_by && $urandom_range(0, 19) != 0) m0_req = 1;
      if (held &&  held_by && $urandom_range(0, 19) != 0) m1_req = 1;
      m0_wr = 1'($urandom); m0_size = 2'($urandom_range(0, 2)); m0_wstrb = 4'($urandom);
      m0_addr = $urandom; m0_wdata = $urandom;
      m1_wr = 1'($urandom); m1_size = 2'($urandom_range(0, 2)); m1_wstrb = 4'($urandom);
      m1_addr = $urandom; m1_wdata = $urandom;
      s_addr_ok = 1'($urandom);
      s_data_ok = (owners.size() > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 99) == 0);
      s_rdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
